// File: rtl/step_pacer.sv
// step_pacer: paced one-cycle inc strobes for the bouncing position counter, keyed start/pause and speed levels.
// Optional build macro PACER_AUTO_LEVEL_EN: every 16th strobe raises the level as if lvl_up were asserted.
module step_pacer #(
  parameter int W    = 24,
  parameter int BASE = 12000000,
  parameter int STEP = 1000000,
  parameter int MINP = 2,
  parameter int LB   = 3,
  parameter int LMAX = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key,
  input  logic          lvl_up,
  input  logic          clr,
  output logic          inc,
  output logic [LB-1:0] level,
  output logic          running,
  output logic          paused,
  output logic [1:0]    state_dbg
);
  // inc is a bare one-cycle strobe: no ready/acknowledge, the counter must consume it the cycle it is high.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  localparam int WL = W + LB;

  state_t        state, state_n;
  logic [W-1:0]  cnt, cnt_n;
  logic [W-1:0]  per, per_n;
  logic [W-1:0]  per_next;
  logic [LB-1:0] lvl_sat, level_n;
  logic          inc_n;
  logic          key_s1, key_s2, key_s3, key_p;
  logic          wrap, bump;
  logic [WL:0]   prod;

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_s3 <= 1'b0;
      key_p  <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      key_p  <= key_s2 & ~key_s3;
    end
  end

  assign wrap = (state == RUN) && (cnt == per - W'(1));

`ifdef PACER_AUTO_LEVEL_EN
  logic [3:0] scnt;
  assign bump = lvl_up | (wrap && (scnt == 4'hF));

  always_ff @(posedge clk) begin
    if (!rst || clr) scnt <= 4'd0;
    else if (inc_n)  scnt <= scnt + 4'd1;
  end
`else
  assign bump = lvl_up;
`endif

  always_comb begin
    lvl_sat = level;
    if (bump && (level != LB'(LMAX))) lvl_sat = level + LB'(1);
  end

  // One spare bit so prod + MINP cannot wrap before the floor comparison.
  always_comb begin
    prod = (WL+1)'(lvl_sat) * (WL+1)'(STEP);
    if (prod + (WL+1)'(MINP) > (WL+1)'(BASE)) per_next = W'(MINP);
    else                                       per_next = W'((WL+1)'(BASE) - prod);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per;
    inc_n   = 1'b0;
    level_n = lvl_sat;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (key_p) begin
          state_n = RUN;
          per_n   = per_next;
        end
      end
      RUN: begin
        if (wrap) begin
          inc_n = 1'b1;
          cnt_n = '0;
          per_n = per_next;
        end else begin
          cnt_n = cnt + W'(1);
        end
        if (key_p) state_n = PAUSE;
      end
      PAUSE: begin
        if (key_p) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
      per_n   = W'(BASE);
      inc_n   = 1'b0;
      level_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      per     <= W'(BASE);
      level   <= '0;
      inc     <= 1'b0;
      running <= 1'b0;
      paused  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      per     <= per_n;
      level   <= level_n;
      inc     <= inc_n;
      running <= (state_n == RUN);
      paused  <= (state_n == PAUSE);
    end
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_step_pacer.sv
// Bench for step_pacer: table vectors, hand-written timing sequences and a random run against a behavioural model.
module tb_step_pacer;
  localparam int W = 8, BASE = 10, STEP = 2, MINP = 2, LB = 3, LMAX = 7;
  localparam int OW = LB + 3;
  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst = 1'b0, key = 1'b0, lvl_up = 1'b0, clr = 1'b0;
  logic inc, running, paused;
  logic [LB-1:0] level;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  // Reference model: started/held flags, cycles elapsed in the current period, period length.
  bit       m_on = 0, m_hold = 0, m_inc = 0;
  int       m_elapsed = 0, m_period = BASE, m_level = 0, m_strobes = 0;
  bit [3:0] m_hist = '0;

  typedef struct {
    bit            r, k, u, c;
    bit            e_inc;
    logic [LB-1:0] e_lvl;
    bit            e_run, e_pau;
    string         name;
  } vec_t;
  vec_t tbl[NV];

  step_pacer #(.W(W), .BASE(BASE), .STEP(STEP), .MINP(MINP), .LB(LB), .LMAX(LMAX)) dut (
    .clk(clk), .rst(rst), .key(key), .lvl_up(lvl_up), .clr(clr),
    .inc(inc), .level(level), .running(running), .paused(paused), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int calc_period(input int lv);
    int v;
    v = BASE - lv * STEP;
    return (v < MINP) ? MINP : v;
  endfunction

  task automatic model_edge();
    bit pulse, bmp;
    int nl;
    pulse = m_hist[2] & ~m_hist[3];
    if (!rst) begin
      m_on = 0; m_hold = 0; m_inc = 0; m_elapsed = 0; m_period = BASE;
      m_level = 0; m_strobes = 0; m_hist = '0;
    end else begin
      m_hist = {m_hist[2:0], key};
      m_inc = 0;
      if (clr) begin
        m_on = 0; m_hold = 0; m_elapsed = 0; m_period = BASE; m_level = 0; m_strobes = 0;
      end else begin
        bmp = lvl_up;
        if (m_on && !m_hold && (m_elapsed + 1 == m_period)) begin
          m_inc = 1;
          m_strobes++;
`ifdef PACER_AUTO_LEVEL_EN
          if (m_strobes % 16 == 0) bmp = 1;
`endif
        end
        nl = bmp ? ((m_level < LMAX) ? m_level + 1 : LMAX) : m_level;
        if (!m_on) begin
          if (pulse) begin
            m_on = 1; m_hold = 0; m_elapsed = 0; m_period = calc_period(nl);
          end
        end else if (m_hold) begin
          if (pulse) m_hold = 0;
        end else begin
          if (m_inc) begin
            m_elapsed = 0;
            m_period = calc_period(nl);
          end else begin
            m_elapsed++;
          end
          if (pulse) m_hold = 1;
        end
        m_level = nl;
      end
    end
    exp_q.push_back({m_inc, LB'(m_level), m_on && !m_hold, m_on && m_hold});
  endtask

  task automatic check_out(input string name);
    logic [OW-1:0] e, a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {inc, level, running, paused};
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got inc/level/run/pause %b want %b", name, a, e);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit k, input bit u, input bit c, input string name);
    rst = r; key = k; lvl_up = u; clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out(name);
  endtask

  task automatic wait_inc(input string name, input int limit, output int n);
    n = 0;
    do begin
      tick(1, 0, 0, 0, name);
      n++;
    end while (!inc && n < limit);
    if (!inc) begin
      checks++;
      errors++;
      $display("FAIL %s: no inc within %0d cycles", name, limit);
    end
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, "reset");
    tick(0, 0, 0, 0, "reset");
  endtask

  // Key held 5 cycles from reset; returns which held cycle first showed running.
  task automatic start_game(output int rise_at);
    rise_at = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1, 1, 0, 0, "start");
      if (running && rise_at == 0) rise_at = i;
    end
  endtask

  task automatic key_pulse_resume(input string name);
    int t;
    tick(1, 1, 0, 0, name);
    tick(1, 1, 0, 0, name);
    t = 0;
    while (!running && t < 8) begin
      tick(1, 0, 0, 0, name);
      t++;
    end
    chk({name, "_running"}, int'(running), 1);
  endtask

  task automatic set_row(input int i, input bit r, input bit k, input bit u, input bit c,
                         input bit ei, input int el, input bit er, input bit ep, input string nm);
    tbl[i].r = r; tbl[i].k = k; tbl[i].u = u; tbl[i].c = c;
    tbl[i].e_inc = ei; tbl[i].e_lvl = LB'(el); tbl[i].e_run = er; tbl[i].e_pau = ep;
    tbl[i].name = nm;
  endtask

  initial begin
    int n, rise, t, incs, notp, elapsed;
    bit kl;
    logic [OW-1:0] ev;

    set_row(0, 0, 0, 0, 0, 0, 0, 0, 0, "tbl_reset");
    set_row(1, 1, 1, 0, 0, 0, 0, 0, 0, "tbl_key_sync1");
    set_row(2, 1, 1, 0, 0, 0, 0, 0, 0, "tbl_key_sync2");
    set_row(3, 1, 1, 0, 0, 0, 0, 0, 0, "tbl_key_edge");
    set_row(4, 1, 1, 0, 0, 0, 0, 1, 0, "tbl_run_rise");
    set_row(5, 1, 0, 1, 0, 0, 1, 1, 0, "tbl_lvl1");
    set_row(6, 1, 0, 1, 0, 0, 2, 1, 0, "tbl_lvl2");
    set_row(7, 1, 0, 1, 1, 0, 0, 0, 0, "tbl_clr_prio");
    set_row(8, 1, 0, 0, 0, 0, 0, 0, 0, "tbl_idle_hold");

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      tick(tbl[i].r, tbl[i].k, tbl[i].u, tbl[i].c, tbl[i].name);
      ev = {tbl[i].e_inc, tbl[i].e_lvl, tbl[i].e_run, tbl[i].e_pau};
      chk(tbl[i].name, int'({inc, level, running, paused}), int'(ev));
    end

    // Start latency, first period, pause and resume from held count.
    do_reset();
    start_game(rise);
    chk("run_latency", rise, 4);
    wait_inc("first_inc", 20, n);
    chk("first_inc_gap", n, 9);
    wait_inc("period_l0", 20, n);
    chk("period_l0", n, 10);
    tick(1, 1, 0, 0, "pause_key");
    tick(1, 1, 0, 0, "pause_key");
    t = 2;
    while (!paused && t < 10) begin
      tick(1, 0, 0, 0, "pause_wait");
      t++;
    end
    chk("pause_latency", t, 4);
    incs = 0; notp = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0, "pause_hold");
      if (inc) incs++;
      if (!paused) notp++;
    end
    chk("pause_no_inc", incs, 0);
    chk("pause_stays", notp, 0);
    key_pulse_resume("resume");
    wait_inc("resume_gap", 20, n);
    chk("resume_gap", n, 6);

    // Level raised mid-period: current period kept, later periods shortened, then floored.
    tick(1, 0, 0, 0, "lvl_mid");
    tick(1, 0, 0, 0, "lvl_mid");
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, "lvl_mid_up");
    chk("level_3", int'(level), 3);
    wait_inc("period_kept", 20, n);
    elapsed = 5 + n;
    chk("period_kept", elapsed, 10);
    wait_inc("period_l3", 20, n);
    chk("period_l3", n, 4);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 0, "lvl_sat_up");
    chk("level_sat", int'(level), 7);
    wait_inc("sync_inc", 20, n);
    wait_inc("period_floor", 20, n);
    chk("period_floor", n, 2);
    wait_inc("period_floor2", 20, n);
    chk("period_floor2", n, 2);

    // key_p coinciding with the terminal count.
    do_reset();
    start_game(rise);
    wait_inc("tc_first", 20, n);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, "tc_idle");
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, "tc_key");
    chk("tc_inc", int'(inc), 1);
    chk("tc_paused", int'(paused), 1);
    chk("tc_not_running", int'(running), 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, "tc_release");
    key_pulse_resume("tc_resume");
    wait_inc("tc_cnt_zero", 20, n);
    chk("tc_cnt_zero", n, 10);

    // clr together with lvl_up at level 5.
    do_reset();
    start_game(rise);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 0, "clr_lvl_up");
    chk("clr_pre_level", int'(level), 5);
    tick(1, 0, 1, 1, "clr_lvl");
    chk("clr_level", int'(level), 0);
    chk("clr_running", int'(running), 0);
    chk("clr_inc", int'(inc), 0);

    // Reset mid-period.
    do_reset();
    start_game(rise);
    tick(1, 0, 1, 0, "rstmid_up");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, "rstmid_run");
    tick(0, 0, 0, 0, "rst_mid");
    chk("rst_mid_outputs", int'({inc, level, running, paused}), 0);

    // Sixteen strobes at level 0.
    do_reset();
    start_game(rise);
    for (int s = 0; s < 16; s++) wait_inc("auto_strobe", 20, n);
    wait_inc("auto_period", 20, n);
`ifdef PACER_AUTO_LEVEL_EN
    chk("auto_level", int'(level), 1);
    chk("auto_period", n, 8);
`else
    chk("auto_level", int'(level), 0);
    chk("auto_period", n, 10);
`endif

    // Random run against the model.
    do_reset();
    kl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) kl = ~kl;
      tick(($urandom_range(0, 399) != 0), kl, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 149) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
